ex_muldiv: RTL and testbench
============================

# ex_muldiv

- Execute-stage multi-cycle multiply/divide unit.
- Consumes operands and operation select from the ID/EX pipeline register outputs.
- Computes a 64-bit product or a quotient/remainder pair into architectural HI/LO registers using an iterative radix-2 datapath.
- Raises a stall to the hazard unit while an operation is in flight.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width.

Ports (one clock; reset is asynchronous and active-high; ports named as in the codebase):
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- srcA  in  WIDTH  rs operand (forwarded gprA).
- srcB  in  WIDTH  rt operand (forwarded gprB).
- flush  in  1  cancels the in-flight operation (branch squash).
- hi_we  in  1  MTHI write.
- lo_we  in  1  MTLO write.
- wdata  in  WIDTH  MTHI/MTLO data.
- stall  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after HI/LO are updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation

- FSM states: IDLE, CALC, FIX.
- IDLE -> CALC when start && !flush.
  - Captures op, sign flags, operand magnitudes and clears the accumulator.
  - Loads the 5-bit counter with 31.
- CALC: one iteration per cycle; counter decrements; CALC -> FIX at counter == 0 (32 iterations).
- FIX -> IDLE unconditionally.
  - Applies sign correction and writes HI/LO.
  - Sets done for the next cycle.
- Multiply (shift-add): 64-bit product. HI = product[63:32], LO = product[31:0].
- Divide (restoring): LO = quotient, HI = remainder.
- Signed ops:
  - Magnitudes are taken at capture.
  - Product and quotient sign = signA ^ signB.
  - Remainder sign = signA.
- Divide by zero (both signednesses): LO = 0xFFFFFFFF, HI = srcA as captured.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- start while state != IDLE: ignored.
- flush:
  - In CALC/FIX: next state IDLE, HI/LO unchanged, no done.
  - With start in IDLE: start is not accepted.
- hi_we/lo_we:
  - Honoured only in IDLE; ignored otherwise.
  - In IDLE, take effect at the clock edge; they cannot collide with a FIX write.
- Reset values: state IDLE, hi = 0, lo = 0, done = 0, stall = 0, counter = 0.
  - Reset mid-operation discards all state.

## Timing

- Cycle 0: start sampled at edge E0.
- E1..E32: CALC iterations.
- E33: FIX writes HI/LO.
- Cycle 34, after E33: done = 1 for one cycle; new HI/LO visible.
- stall is high from E0 through E33 (33 cycles) and low in the done cycle.
- The unit accepts a new start in the same cycle done is high.
- stall is a combinational decode of state; no combinational path from start to stall.
- hi/lo are registered outputs with no bypass. A MFHI/MFLO in EX during the done cycle reads the new values.

## Configuration

- MULDIV_SIGNED_EN defined:
  - op[0] selects signed operation.
  - Magnitude conversion and FIX sign correction are built.
- MULDIV_SIGNED_EN undefined:
  - op[0] is ignored; all operations are unsigned.
  - FIX still occupies one cycle but performs no correction, so latency is identical.
  - The signed-overflow rule is absent.

## Structure

- Shared processor package holds:
  - the op encodings (MD_MULTU, MD_MULT, MD_DIVU, MD_DIV);
  - the FSM state encoding;
  - the ITER_COUNT = 32 constant.
- One sub-module is natural: md_step, the combinational single-iteration datapath.
  - Multiply: add-and-shift. Divide: trial-subtract-and-shift.
  - ex_muldiv owns the FSM, counter, capture registers and HI/LO.

## Test plan

- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; done in cycle 34; stall high exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Without MULDIV_SIGNED_EN -> HI = 0x00000006, LO = 0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000005.
- Preload HI = 0x11, LO = 0x22 via MTHI/MTLO, start DIVU 100/7, flush at cycle 10 -> stall low at cycle 11, no done, HI/LO remain 0x11/0x22.
- Assert rst at cycle 20 of a MULTU -> stall, done, hi, lo = 0 immediately. Start after release with 6 x 7 -> LO = 42, HI = 0.
- start while busy and hi_we while busy -> ignored. start and flush together in IDLE -> not accepted, stall stays 0.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_pkg
// Shared definitions for the execute-stage multiply/divide unit:
//   - MD_* operation encodings carried on the 2-bit op select
//   - FSM state encoding (IDLE / CALC / FIX)
//   - ITER_COUNT: number of radix-2 iterations per operation
// Optional feature macro used by the importing RTL: MULDIV_SIGNED_EN.
// ---------------------------------------------------------------------------
package ex_muldiv_pkg;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_md_step.sv
// ---------------------------------------------------------------------------
// ex_muldiv_md_step
// Combinational single iteration of the radix-2 multiply/divide datapath.
//   Multiply (shift-add): {acc,q} holds {partial product high, multiplier};
//     the multiplicand b is added when q[0] is set, then the pair shifts right.
//   Divide (restoring): {acc,q} holds {partial remainder, dividend/quotient};
//     the pair shifts left, b is trial-subtracted and the quotient bit enters
//     at q[0].
// Ports:
//   is_div_i        1      select divide step (0 = multiply step)
//   acc_i / acc_o   WIDTH  upper working register in / out
//   q_i / q_o       WIDTH  lower working register in / out
//   b_i             WIDTH  multiplicand or divisor magnitude
// ---------------------------------------------------------------------------
module ex_muldiv_md_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + (q_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
    shifted = {acc_i, q_i[WIDTH-1]};
    // Only used when shifted >= b, so the result always fits in WIDTH bits.
    diff    = shifted[WIDTH-1:0] - b_i;
    if (is_div_i) begin
      if (shifted >= {1'b0, b_i}) begin
        acc_o = diff;
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add becomes the new MSB of the shifted pair.
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
// Execute-stage multi-cycle multiply/divide unit with architectural HI/LO.
// One operation takes 1 capture + 32 CALC + 1 FIX cycles; stall is asserted
// for every non-IDLE state and done pulses for one cycle after HI/LO update.
// Divide by zero yields LO = all ones, HI = dividend as captured; in signed
// mode 0x80000000 / -1 yields LO = 0x80000000, HI = 0 (both fall out of the
// magnitude datapath plus the sign fix-up below).
// Build option: MULDIV_SIGNED_EN -- when defined op[0] selects signed
// operation (magnitude capture and FIX sign correction are built); when
// undefined every operation is unsigned and FIX is a plain write cycle.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, op       launch request and MD_* operation select (IDLE only)
//   srcA, srcB      rs / rt operands
//   flush           cancel in-flight operation / block a launch in IDLE
//   hi_we, lo_we    MTHI / MTLO write enables (IDLE only), data on wdata
//   stall           high whenever the FSM is not IDLE
//   done            one-cycle pulse after HI/LO were written by an operation
//   hi, lo          HI / LO registers
// ---------------------------------------------------------------------------
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER_COUNT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_div_q;
  logic [WIDTH-1:0] acc_q, qr_q, b_q;
  logic [WIDTH-1:0] acc_n, qr_n;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             accept;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v,
                                             input logic             n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v,
                                                input logic               n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign accept = (state_q == ST_IDLE) && start && !flush;

`ifdef MULDIV_SIGNED_EN
  logic op_signed;
  logic neg_a, neg_b;
  logic sa_q, sb_q, div0_q;

  assign op_signed = md_is_signed(op);
  assign neg_a     = op_signed & srcA[WIDTH-1];
  assign neg_b     = op_signed & srcB[WIDTH-1];
  assign mag_a     = neg_w(srcA, neg_a);
  assign mag_b     = neg_w(srcB, neg_b);

  always_ff @(posedge clk) begin
    if (accept) begin
      sa_q   <= neg_a;
      sb_q   <= neg_b;
      div0_q <= (srcB == '0);
    end
  end

  // The remainder takes the dividend's sign, which also restores HI = srcA on
  // divide by zero; the all-ones quotient of a zero divisor is left unsigned.
  always_comb begin
    res_hi = acc_q;
    res_lo = qr_q;
    if (is_div_q) begin
      res_lo = neg_w(qr_q, (sa_q ^ sb_q) & ~div0_q);
      res_hi = neg_w(acc_q, sa_q);
    end else begin
      {res_hi, res_lo} = neg_2w({acc_q, qr_q}, sa_q ^ sb_q);
    end
  end
`else
  logic unused_op0;

  assign unused_op0 = op[0];
  assign mag_a      = srcA;
  assign mag_b      = srcB;
  assign res_hi     = acc_q;
  assign res_lo     = qr_q;
`endif

  ex_muldiv_md_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .q_i      (qr_q),
    .b_i      (b_q),
    .acc_o    (acc_n),
    .q_o      (qr_n)
  );

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !flush) state_d = ST_CALC;
      ST_CALC: begin
        if (flush)              state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: stall decodes the registered state only
  always_comb begin
    stall = (state_q != ST_IDLE);
  end

  // Counter, done and HI/LO next-state
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (accept) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == ST_CALC) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (state_q == ST_IDLE) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end else if ((state_q == ST_FIX) && !flush) begin
      hi_d   = res_hi;
      lo_d   = res_lo;
      done_d = 1'b1;
    end
  end

  // Control and architectural state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Working datapath: both operations start from {0, |A|} with |B| held aside
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q    <= '0;
      qr_q     <= mag_a;
      b_q      <= mag_b;
      is_div_q <= md_is_div(op);
    end else if (state_q == ST_CALC) begin
      acc_q <= acc_n;
      qr_q  <= qr_n;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] srcA, srcB, wdata;
  logic        stall, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic        sgn;
    longint      la, lb;
    logic [63:0] qq, rr;
`ifdef MULDIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    la = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    lb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o[1]) return 64'(la * lb);
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    qq = 64'(la / lb);
    rr = 64'(la % lb);
    return {rr[31:0], qq[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 (hi=%h lo=%h), required no done", hi, lo);
      end else begin
        e = sb_q.pop_front();
        check("result_hi_lo", {hi, lo}, e);
      end
    end
  end

  // Launch at the current negedge; returns at the negedge of the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit poke_busy);
    int n;
    start = 1'b1; op = o; srcA = a; srcB = b;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    check("done_width", {63'b0, done}, 64'd0);
    n = 0;
    while (stall && n < 100) begin
      n++;
      if (poke_busy && n == 5) begin
        start = 1'b1; op = ~o; srcA = $urandom; srcB = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("stall_cycles", 64'(n), 64'd33);
    check("done_pulse", {63'b0, done}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; srcA = '0; srcB = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {30'b0, stall, done, hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, issued back to back (each starts in the previous done cycle)
    do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
`ifdef MULDIV_SIGNED_EN
    do_op(MD_MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
    do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    do_op(MD_DIV, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 1'b0);
`else
    do_op(MD_MULT, 32'hFFFFFFFD, 32'd7, 64'h00000006_FFFFFFEB, 1'b0);
    do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 1'b0);
    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 1'b0);
    do_op(MD_DIV, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 1'b0);
`endif
    do_op(MD_DIVU, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      do_op(o, a, b, ref_model(o, a, b), (i % 8) == 3);
    end

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wdata = 32'h11;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'h11, 32'h22});

    // DIVU 100/7 flushed in cycle 10; MTHI/MTLO while busy must be ignored
    start = 1'b1; op = MD_DIVU; srcA = 32'd100; srcB = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      hi_we = (c == 3); lo_we = (c == 3); wdata = 32'hDEAD;
      if (c == 10) begin
        check("stall_before_flush", {63'b0, stall}, 64'd1);
        flush = 1'b1;
      end
    end
    @(negedge clk);
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("stall_after_flush", {62'b0, stall, done}, 64'd0);
    repeat (30) @(negedge clk);
    check("hi_lo_after_flush", {hi, lo}, {32'h11, 32'h22});

    // Asynchronous reset in cycle 20 of a MULTU
    start = 1'b1; op = MD_MULTU; srcA = 32'h12345; srcB = 32'h6789;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("reset_mid_op", {30'b0, stall, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    do_op(MD_MULTU, 32'd6, 32'd7, 64'd42, 1'b0);

    // Flush arriving in the FIX cycle cancels the write
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; srcA = 32'd3; srcB = 32'd5;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("stall_in_fix", {63'b0, stall}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fix_flush_no_done", {62'b0, stall, done}, 64'd0);
    check("fix_flush_hi_lo", {hi, lo}, 64'd42);

    // start together with flush in IDLE is not accepted
    start = 1'b1; flush = 1'b1; op = MD_DIVU; srcA = 32'd9; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle", {63'b0, stall}, 64'd0);
    repeat (5) @(negedge clk);
    check("start_flush_idle_later", {62'b0, stall, done}, 64'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
